gpio_arb: RTL and testbench
===========================

Name: gpio_arb

Overview:
Round-robin arbiter that shares the single GPIO register port (2-bit address, write enable, 32-bit write data, 32-bit read data) between NREQ bus requesters, e.g. CPU data port and debug/DMA master.
Each accepted request becomes exactly one GPIO access, followed by a one-cycle completion pulse that returns the read data.
Sits between the requesters and the GPIO peripheral; the GPIO block's read path is combinational, and its writes commit on the clock edge.

Parameters:
NREQ, 2, number of requesters (2..4)
DW, 32, data width of write and read data

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req  in  NREQ  per-requester request
req_we  in  NREQ  per-requester write enable (1=write, 0=read)
req_a  in  2*NREQ  per-requester GPIO address; requester i uses slice [2i+1:2i]
req_wd  in  DW*NREQ  per-requester write data; requester i uses slice [DW*i+DW-1:DW*i]
gnt  out  NREQ  one-hot grant, combinational; request i is accepted on an edge where req[i]&gnt[i]
done  out  NREQ  one-hot registered completion pulse, one cycle wide
rdata  out  DW  registered read data, valid while done is high
busy  out  1  high in ACCESS state
gpio_a  out  2  GPIO address
gpio_we  out  1  GPIO write enable
gpio_wd  out  DW  GPIO write data
gpio_rd  in  DW  GPIO read data (combinational from gpio_a)

Behaviour:
- Decided: single clock clk; rst is asynchronous, active-high.
- Reset values:
  - state=IDLE
  - ptr=NREQ-1, so requester 0 has first priority
  - done=0, rdata=0
  - captured a/we/wd/index=0
  - Consequences: gnt=0 while rst is high; gpio_we=0, gpio_a=0, gpio_wd=0, busy=0.
- States: IDLE, ACCESS.
- IDLE:
  - gnt = one-hot winner among req, searching from ptr+1 upward with wrap modulo NREQ; gnt=0 if req=0.
  - On an edge with a winner w: capture req_a[w], req_we[w], req_wd[w] and w; set ptr=w; go to ACCESS.
- ACCESS:
  - gnt=0.
  - gpio_a, gpio_wd = captured values; gpio_we = captured we; busy=1.
  - On the next edge: rdata<=gpio_rd (sampled for writes too; don't-care to requester), done[w]<=1, go to IDLE.
- Outside ACCESS: gpio_we=0; gpio_a and gpio_wd hold the last captured values.
- done is high for exactly the cycle after ACCESS, then cleared.
- Latency: accept edge k -> GPIO write commits at edge k+1 -> done/rdata visible in cycle after edge k+1.
- Throughput: one access per 2 cycles. A new grant may be issued in the same cycle as done.
- Requester rules:
  - Hold req, req_we, req_a, req_wd stable until accepted.
  - Deassert req, or present the next request, after the accept edge.
  - The arbiter never re-grants the same request without a new accept.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 other accesses.
- req dropped before accept: no access is issued for it, and there is no side effect.
- Addresses are not filtered. Writes to read-only addresses pass through; the GPIO decoder ignores them.
- Reset asserted in ACCESS: state goes to IDLE immediately (async), gpio_we drops at once, and no done pulse is produced.
- Reset deasserted: the first grant favours requester 0.

Decomposition:
- Package gpio_arb_pkg:
  - state enum {IDLE, ACCESS}
  - GPIO address constants ADDR_GPI1=2'd0, ADDR_GPI2=2'd1, ADDR_GPO1=2'd2, ADDR_GPO2=2'd3
- Sub-module rr_pick: combinational, parameter NREQ; inputs req and ptr; output one-hot gnt plus binary index. Reusable for other shared peripherals.
- Registers stay in gpio_arb.

Test Plan:
- Single write:
  - Stimulus: req0 write a=2, wd=32'hDEADBEEF.
  - Response: gnt0 in same cycle; gpio_we=1 for exactly one cycle with a=2; GPO1 reads 32'hDEADBEEF; done0 one cycle later, done1 stays 0.
- Single read:
  - Stimulus: gpi2=32'h0000_1234; req1 read a=1.
  - Response: done1 pulses with rdata=32'h0000_1234; gpio_we stays 0 throughout.
- Contention and rotation:
  - Stimulus: req0 and req1 both held, each re-requesting right after its accept, 6 accesses.
  - Response: grant order 0,1,0,1,0,1; one access every 2 cycles; no cycle with two gnt bits set.
- Back-to-back same requester:
  - Stimulus: req0 writes a=3 wd=1, then a=3 wd=2, with req1 idle.
  - Response: two accesses 2 cycles apart; GPO2 ends at 2; exactly two done0 pulses.
- Reset mid-access:
  - Stimulus: assert rst asynchronously during ACCESS of a write of wd=32'h55 to a=2.
  - Response: gpio_we=0 immediately; no done pulse; after release, busy=0 and rdata=0; a simultaneous req0/req1 after release grants requester 0 first.
- Withdrawn request:
  - Stimulus: req1 raised for one cycle while ACCESS serves requester 0, then dropped.
  - Response: no access for requester 1; done1 never pulses.

Source files
------------

// File: rtl/gpio_arb_pkg.sv
// rtl/gpio_arb_pkg.sv - shared types and GPIO register map for the GPIO port arbiter
package gpio_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [1:0] ADDR_GPI1 = 2'd0;
  localparam logic [1:0] ADDR_GPI2 = 2'd1;
  localparam logic [1:0] ADDR_GPO1 = 2'd2;
  localparam logic [1:0] ADDR_GPO2 = 2'd3;

endpackage

// File: rtl/gpio_arb_rr_pick.sv
// rtl/gpio_arb_rr_pick.sv - combinational round-robin picker, searches upward from ptr+1 with wrap
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 2) ? 2 : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic          w_found;
  logic [IW-1:0] w_cand;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(ptr) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found     = 1'b1;
        gnt[w_cand] = 1'b1;
        idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/gpio_arb.sv
// rtl/gpio_arb.sv - round-robin arbiter sharing one GPIO register port between NREQ requesters
module gpio_arb
  import gpio_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [2*NREQ-1:0]  req_a,
  input  logic [DW*NREQ-1:0] req_wd,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic [1:0]         gpio_a,
  output logic               gpio_we,
  output logic [DW-1:0]      gpio_wd,
  input  logic [DW-1:0]      gpio_rd
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [1:0]      r_a;
  logic            r_we;
  logic [DW-1:0]   r_wd;
  logic [DW-1:0]   r_rdata;
  logic [NREQ-1:0] r_done;

  logic [NREQ-1:0] w_pick_gnt;
  logic [IW-1:0]   w_pick_idx;
  logic [NREQ-1:0] w_gnt;
  logic            w_accept;
  logic [1:0]      w_sel_a;
  logic            w_sel_we;
  logic [DW-1:0]   w_sel_wd;
  logic [NREQ-1:0] w_done_nxt;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_pick_gnt),
    .idx (w_pick_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = '0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        // Grant is suppressed while reset is held so no requester sees a phantom accept.
        w_gnt = rst ? '0 : w_pick_gnt;
        if (|w_pick_gnt) begin
          w_accept    = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_sel_a    = '0;
    w_sel_we   = 1'b0;
    w_sel_wd   = '0;
    w_done_nxt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_idx == IW'(i)) begin
        w_sel_a  = req_a[2*i +: 2];
        w_sel_we = req_we[i];
        w_sel_wd = req_wd[DW*i +: DW];
      end
      w_done_nxt[i] = (r_state == ACCESS) && (r_idx == IW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= IW'(NREQ - 1);
      r_idx   <= '0;
      r_a     <= '0;
      r_we    <= 1'b0;
      r_wd    <= '0;
      r_rdata <= '0;
      r_done  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_ptr <= w_pick_idx;
        r_idx <= w_pick_idx;
        r_a   <= w_sel_a;
        r_we  <= w_sel_we;
        r_wd  <= w_sel_wd;
      end
      if (r_state == ACCESS) begin
        r_rdata <= gpio_rd;
      end
    end
  end

  assign gnt     = w_gnt;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign busy    = (r_state == ACCESS);
  assign gpio_a  = r_a;
  assign gpio_we = (r_state == ACCESS) && r_we;
  assign gpio_wd = r_wd;

endmodule

// File: tb/tb_gpio_arb.sv
// tb/tb_gpio_arb.sv - self-checking bench for gpio_arb against a transaction-level reference model
module tb_gpio_arb;
  import gpio_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    req_we;
  logic [2*NREQ-1:0]  req_a;
  logic [DW*NREQ-1:0] req_wd;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic [1:0]         gpio_a;
  logic               gpio_we;
  logic [DW-1:0]      gpio_wd;
  logic [DW-1:0]      gpio_rd;

  logic          t_we [NREQ];
  logic [1:0]    t_a  [NREQ];
  logic [DW-1:0] t_wd [NREQ];

  logic [31:0] gpi1 = '0;
  logic [31:0] gpi2 = '0;
  logic [31:0] gpo1 = '0;
  logic [31:0] gpo2 = '0;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: one outstanding transaction, last-served pointer, GPO shadow
  bit              m_busy;
  int              m_last;
  int              m_srv;
  logic            m_we;
  logic [1:0]      m_a;
  logic [31:0]     m_wd;
  logic [31:0]     m_rd;
  bit              m_rd_valid;
  logic [NREQ-1:0] m_done;
  logic [31:0]     m_gpo [2];
  bit              acc [NREQ];

  gpio_arb #(.NREQ(NREQ), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_we  (req_we),
    .req_a   (req_a),
    .req_wd  (req_wd),
    .gnt     (gnt),
    .done    (done),
    .rdata   (rdata),
    .busy    (busy),
    .gpio_a  (gpio_a),
    .gpio_we (gpio_we),
    .gpio_wd (gpio_wd),
    .gpio_rd (gpio_rd)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_we = '0;
    req_a  = '0;
    req_wd = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_we[i]          = t_we[i];
      req_a[2*i +: 2]    = t_a[i];
      req_wd[DW*i +: DW] = t_wd[i];
    end
  end

  always_comb begin
    gpio_rd = gpi1;
    case (gpio_a)
      ADDR_GPI1: gpio_rd = gpi1;
      ADDR_GPI2: gpio_rd = gpi2;
      ADDR_GPO1: gpio_rd = gpo1;
      ADDR_GPO2: gpio_rd = gpo2;
      default:   gpio_rd = gpi1;
    endcase
  end

  always @(posedge clk) begin
    if (gpio_we) begin
      if (gpio_a == ADDR_GPO1) gpo1 <= gpio_wd;
      else if (gpio_a == ADDR_GPO2) gpo2 <= gpio_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] gpio_val(input logic [1:0] a);
    case (a)
      2'd0:    return gpi1;
      2'd1:    return gpi2;
      2'd2:    return m_gpo[0];
      default: return m_gpo[1];
    endcase
  endfunction

  task automatic m_reset();
    m_busy     = 1'b0;
    m_last     = NREQ - 1;
    m_done     = '0;
    m_rd_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model, land at posedge+1.
  task automatic step();
    int w;
    logic [NREQ-1:0] exp_gnt;
    @(negedge clk);
    w = -1;
    if (!m_busy) begin
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (m_last + k) % NREQ;
        if (w < 0 && req[j]) w = j;
      end
    end
    exp_gnt = (w >= 0) ? (NREQ'(1) << w) : '0;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("gpio_we", 32'(gpio_we), 32'(m_busy && m_we));
    if (m_busy) begin
      chk("gpio_a", 32'(gpio_a), 32'(m_a));
      chk("gpio_wd", gpio_wd, m_wd);
    end
    chk("done", 32'(done), 32'(m_done));
    if (m_done != '0 && m_rd_valid) chk("rdata", rdata, m_rd);

    for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
    if (m_busy) begin
      m_rd       = gpio_val(m_a);
      m_rd_valid = !m_we;
      if (m_we && m_a[1]) m_gpo[m_a[0]] = m_wd;
      m_done = NREQ'(1) << m_srv;
      m_busy = 1'b0;
    end else begin
      m_done = '0;
      if (w >= 0) begin
        m_busy = 1'b1;
        m_srv  = w;
        m_last = w;
        m_we   = t_we[w];
        m_a    = t_a[w];
        m_wd   = t_wd[w];
        acc[w] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic new_txn(input int i);
    req[i]  = 1'b1;
    t_we[i] = 1'($urandom % 2);
    t_a[i]  = 2'($urandom % 4);
    t_wd[i] = $urandom;
  endtask

  task automatic drive(input bit heavy);
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        if (heavy || ($urandom % 3) != 0) new_txn(i);
        else req[i] = 1'b0;
      end else if (req[i]) begin
        if (!heavy && ($urandom % 12) == 0) req[i] = 1'b0;
      end else if (heavy || ($urandom % 3) == 0) begin
        new_txn(i);
      end
    end
    if (($urandom % 8) == 0) gpi1 = $urandom;
    if (($urandom % 8) == 0) gpi2 = $urandom;
  endtask

  initial begin
    m_gpo[0] = '0;
    m_gpo[1] = '0;
    for (int i = 0; i < NREQ; i++) begin
      t_we[i] = 1'b0;
      t_a[i]  = '0;
      t_wd[i] = '0;
    end
    m_reset();

    req = '1;
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_gpio_we", 32'(gpio_we), 32'd0);
    chk("rst_gpio_a", 32'(gpio_a), 32'd0);
    chk("rst_gpio_wd", gpio_wd, 32'd0);
    req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    t_we[0] = 1'b1; t_a[0] = ADDR_GPO1; t_wd[0] = 32'hDEADBEEF; req[0] = 1'b1;
    step();
    req[0] = 1'b0;
    step();
    step();
    chk("gpo1_write", gpo1, 32'hDEADBEEF);

    gpi2 = 32'h0000_1234;
    t_we[1] = 1'b0; t_a[1] = ADDR_GPI2; req[1] = 1'b1;
    step();
    req[1] = 1'b0;
    step();
    step();
    chk("gpi2_read", rdata, 32'h0000_1234);

    t_we[0] = 1'b1; t_a[0] = ADDR_GPO2; t_wd[0] = 32'd1; req[0] = 1'b1;
    step();
    t_wd[0] = 32'd2;
    step();
    step();
    req[0] = 1'b0;
    step();
    step();
    chk("gpo2_b2b", gpo2, 32'd2);

    t_we[0] = 1'b1; t_a[0] = ADDR_GPO1; t_wd[0] = 32'h55; req[0] = 1'b1;
    step();
    req[0] = 1'b0;
    chk("we_before_rst", 32'(gpio_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("we_async_rst", 32'(gpio_we), 32'd0);
    chk("busy_async_rst", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("gpo1_kept", gpo1, 32'hDEADBEEF);
    rst = 1'b0;
    m_reset();
    chk("rdata_after_rst", rdata, 32'd0);
    chk("done_after_rst", 32'(done), 32'd0);
    t_we[0] = 1'b0; t_a[0] = ADDR_GPI1;
    t_we[1] = 1'b0; t_a[1] = ADDR_GPI2;
    req = '1;
    step();

    for (int phase = 0; phase < 4; phase++) begin
      repeat (200) begin
        drive(phase[0]);
        step();
      end
    end

    req = '0;
    repeat (3) step();
    chk("gpo1_final", gpo1, m_gpo[0]);
    chk("gpo2_final", gpo2, m_gpo[1]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
